// File: rtl/lvt_ram_pkg.sv
// Shared types and constants for the LVT RAM self-test initiator.
// Holds the FSM encoding and the address-derived test pattern.
package lvt_ram_pkg;

   localparam int BLOCKSIZE = 10;
   localparam int ADDR_W    = BLOCKSIZE + 1;
   localparam int DATA_W    = 32;
   localparam int NPORT     = 8;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      FLUSH,
      DONE
   } bist_state_t;

   function automatic logic [DATA_W-1:0] bist_pat(
      input logic [DATA_W-1:0] seed,
      input logic [DATA_W-1:0] addr
   );
      return seed + addr;
   endfunction

endpackage

// File: rtl/lvt_bist_cmp.sv
// Read-data checker: carries expected words alongside RAM latency,
// compares all lanes, counts mismatches and picks the lowest failing lane.
module lvt_bist_cmp
   import lvt_ram_pkg::*;
#(
   parameter int AW     = 11,
   parameter int RD_LAT = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         issue,
   input  logic [NPORT-1:0][AW-1:0]     issue_addr,
   input  logic [NPORT-1:0][DATA_W-1:0] issue_exp,
   input  logic [NPORT-1:0][DATA_W-1:0] r_dout,
   output logic [3:0]                   mism_cnt,
   output logic                         mism_any,
   output logic [2:0]                   first_port,
   output logic [AW-1:0]                first_addr
);

   logic [RD_LAT-1:0]               vld;
   logic [NPORT-1:0][AW-1:0]        pa [RD_LAT];
   logic [NPORT-1:0][DATA_W-1:0]    pe [RD_LAT];
   logic [NPORT-1:0]                mism;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld <= '0;
      end else begin
         vld[0] <= issue;
         for (int i = 1; i < RD_LAT; i++)
            vld[i] <= vld[i-1];
      end
   end

   always_ff @(posedge clk) begin
      pa[0] <= issue_addr;
      pe[0] <= issue_exp;
      for (int i = 1; i < RD_LAT; i++) begin
         pa[i] <= pa[i-1];
         pe[i] <= pe[i-1];
      end
   end

   // Walk lanes high to low so the lowest mismatching lane is the last writer.
   always_comb begin
      mism       = '0;
      mism_cnt   = '0;
      first_port = '0;
      first_addr = '0;
      for (int k = NPORT - 1; k >= 0; k--) begin
         mism[k]  = vld[RD_LAT-1] && (r_dout[k] != pe[RD_LAT-1][k]);
         mism_cnt = mism_cnt + 4'(mism[k]);
         if (mism[k]) begin
            first_port = 3'(k);
            first_addr = pa[RD_LAT-1][k];
         end
      end
   end

   assign mism_any = |mism;

endmodule

// File: rtl/lvt_ram_bist.sv
// Self-test initiator for the 8R8W LVT RAM: fill, read back and check
// the whole array twice, with the seed and then its complement.
module lvt_ram_bist #(
   parameter int          BLOCKSIZE = lvt_ram_pkg::BLOCKSIZE,
   parameter int          RD_LAT    = 1,
   parameter logic [31:0] SEED      = 32'hA5A5_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic [BLOCKSIZE:0]   w_addr_1,
   output logic [BLOCKSIZE:0]   w_addr_2,
   output logic [BLOCKSIZE:0]   w_addr_3,
   output logic [BLOCKSIZE:0]   w_addr_4,
   output logic [BLOCKSIZE:0]   w_addr_5,
   output logic [BLOCKSIZE:0]   w_addr_6,
   output logic [BLOCKSIZE:0]   w_addr_7,
   output logic [BLOCKSIZE:0]   w_addr_8,
   output logic [31:0]          w_din_1,
   output logic [31:0]          w_din_2,
   output logic [31:0]          w_din_3,
   output logic [31:0]          w_din_4,
   output logic [31:0]          w_din_5,
   output logic [31:0]          w_din_6,
   output logic [31:0]          w_din_7,
   output logic [31:0]          w_din_8,
   output logic                 w_enb_1,
   output logic                 w_enb_2,
   output logic                 w_enb_3,
   output logic                 w_enb_4,
   output logic                 w_enb_5,
   output logic                 w_enb_6,
   output logic                 w_enb_7,
   output logic                 w_enb_8,
   output logic [BLOCKSIZE:0]   r_addr_1,
   output logic [BLOCKSIZE:0]   r_addr_2,
   output logic [BLOCKSIZE:0]   r_addr_3,
   output logic [BLOCKSIZE:0]   r_addr_4,
   output logic [BLOCKSIZE:0]   r_addr_5,
   output logic [BLOCKSIZE:0]   r_addr_6,
   output logic [BLOCKSIZE:0]   r_addr_7,
   output logic [BLOCKSIZE:0]   r_addr_8,
   input  logic [31:0]          r_dout_1,
   input  logic [31:0]          r_dout_2,
   input  logic [31:0]          r_dout_3,
   input  logic [31:0]          r_dout_4,
   input  logic [31:0]          r_dout_5,
   input  logic [31:0]          r_dout_6,
   input  logic [31:0]          r_dout_7,
   input  logic [31:0]          r_dout_8,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [15:0]          err_cnt,
   output logic [BLOCKSIZE:0]   first_err_addr,
   output logic [2:0]           first_err_port
);

   import lvt_ram_pkg::*;

   localparam int AW    = BLOCKSIZE + 1;
   localparam int DEPTH = 2 ** AW;
   localparam logic [AW-1:0] LAST = AW'(DEPTH - NPORT);

   bist_state_t                  state;
   logic [AW-1:0]                base;
   logic                         pass_idx;
   logic [1:0]                   fl_cnt;
   logic [DATA_W-1:0]            seed_p;
   logic                         wr, rd, start_ok;
   logic [NPORT-1:0][AW-1:0]     lane_addr, wa, ra;
   logic [NPORT-1:0][DATA_W-1:0] lane_dat, wd, rdat;
   logic [NPORT-1:0]             we;
   logic [3:0]                   mism_cnt;
   logic                         mism_any;
   logic [2:0]                   cmp_port;
   logic [AW-1:0]                cmp_addr;
   logic [16:0]                  err_sum;

   assign wr       = (state == WRITE);
   assign rd       = (state == READ);
   assign start_ok = start && (state == IDLE || state == DONE);
   assign seed_p   = pass_idx ? ~SEED : SEED;

   always_comb begin
      lane_addr = '0;
      lane_dat  = '0;
      wa        = '0;
      wd        = '0;
      ra        = '0;
      for (int k = 0; k < NPORT; k++) begin
         lane_addr[k] = base | AW'(k);
         lane_dat[k]  = bist_pat(seed_p, 32'(lane_addr[k]));
         wa[k]        = wr ? lane_addr[k] : '0;
         wd[k]        = wr ? lane_dat[k] : '0;
         ra[k]        = rd ? lane_addr[k] : '0;
      end
   end

   assign we = {NPORT{wr}};

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         base     <= '0;
         pass_idx <= 1'b0;
         fl_cnt   <= '0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  state    <= WRITE;
                  base     <= '0;
                  pass_idx <= 1'b0;
               end
            end
            WRITE: begin
               if (base == LAST) begin
                  base  <= '0;
                  state <= READ;
               end else begin
                  base <= base + AW'(NPORT);
               end
            end
            READ: begin
               if (base == LAST) begin
                  base   <= '0;
                  fl_cnt <= '0;
                  state  <= FLUSH;
               end else begin
                  base <= base + AW'(NPORT);
               end
            end
            FLUSH: begin
               if (fl_cnt == 2'(RD_LAT - 1)) begin
                  pass_idx <= 1'b1;
                  state    <= pass_idx ? DONE : WRITE;
               end else begin
                  fl_cnt <= fl_cnt + 2'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign err_sum = {1'b0, err_cnt} + 17'(mism_cnt);

   always_ff @(posedge clk) begin
      if (rst || start_ok) begin
         err_cnt        <= '0;
         first_err_addr <= '0;
         first_err_port <= '0;
      end else if (mism_any) begin
         err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
         if (err_cnt == '0) begin
            first_err_addr <= cmp_addr;
            first_err_port <= cmp_port;
         end
      end
   end

   lvt_bist_cmp #(
      .AW     (AW),
      .RD_LAT (RD_LAT)
   ) u_cmp (
      .clk        (clk),
      .rst        (rst),
      .issue      (rd),
      .issue_addr (lane_addr),
      .issue_exp  (lane_dat),
      .r_dout     (rdat),
      .mism_cnt   (mism_cnt),
      .mism_any   (mism_any),
      .first_port (cmp_port),
      .first_addr (cmp_addr)
   );

   assign busy = wr || rd || (state == FLUSH);
   assign done = (state == DONE);
   assign pass = done && (err_cnt == '0);

   assign rdat = {r_dout_8, r_dout_7, r_dout_6, r_dout_5,
                  r_dout_4, r_dout_3, r_dout_2, r_dout_1};

   assign w_addr_1 = wa[0];
   assign w_addr_2 = wa[1];
   assign w_addr_3 = wa[2];
   assign w_addr_4 = wa[3];
   assign w_addr_5 = wa[4];
   assign w_addr_6 = wa[5];
   assign w_addr_7 = wa[6];
   assign w_addr_8 = wa[7];
   assign w_din_1  = wd[0];
   assign w_din_2  = wd[1];
   assign w_din_3  = wd[2];
   assign w_din_4  = wd[3];
   assign w_din_5  = wd[4];
   assign w_din_6  = wd[5];
   assign w_din_7  = wd[6];
   assign w_din_8  = wd[7];
   assign w_enb_1  = we[0];
   assign w_enb_2  = we[1];
   assign w_enb_3  = we[2];
   assign w_enb_4  = we[3];
   assign w_enb_5  = we[4];
   assign w_enb_6  = we[5];
   assign w_enb_7  = we[6];
   assign w_enb_8  = we[7];
   assign r_addr_1 = ra[0];
   assign r_addr_2 = ra[1];
   assign r_addr_3 = ra[2];
   assign r_addr_4 = ra[3];
   assign r_addr_5 = ra[4];
   assign r_addr_6 = ra[5];
   assign r_addr_7 = ra[6];
   assign r_addr_8 = ra[7];

endmodule

// File: doc/lvt_ram_bist.md
# lvt_ram_bist

Synthesizable built-in self-test initiator for the 8-read/8-write LVT RAM (`ram_8R8W`). It sits on the opposite side of the RAM's port bundle and drives all eight write ports and all eight read ports. On `start` it fills the whole array with an address-derived pattern, reads it back on all read ports, checks every word, then repeats the fill and check with the complemented seed. It reports `done`, `pass`, an error count and the first failing location.

## Interface
Parameters:
- `BLOCKSIZE`, default 10: address MSB index; address width is BLOCKSIZE+1 and depth is 2^(BLOCKSIZE+1).
- `RD_LAT`, default 1: RAM read latency in cycles from `r_addr_k` to `r_dout_k`; legal range 1..4.
- `SEED`, default 32'hA5A5_0000: pattern seed for pass 0.

Ports (k = 1..8):
- `clk` input 1: single clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle request to begin a test.
- `w_addr_k` output BLOCKSIZE+1: write address, port k.
- `w_din_k` output 32: write data, port k.
- `w_enb_k` output 1: write enable, port k.
- `r_addr_k` output BLOCKSIZE+1: read address, port k.
- `r_dout_k` input 32: read data, port k.
- `busy` output 1: test in progress.
- `done` output 1: test finished; held until the next accepted `start` or `rst`.
- `pass` output 1: valid while `done`; 1 iff `err_cnt` == 0.
- `err_cnt` output 16: mismatch count, saturates at 16'hFFFF.
- `first_err_addr` output BLOCKSIZE+1: address of the first mismatch.
- `first_err_port` output 3: zero-based read port of the first mismatch.

## Operation
- FSM states: IDLE, WRITE, READ, FLUSH, DONE.
  - IDLE or DONE with `start`=1 → WRITE. Clears `err_cnt`, the first-error registers, `base` and `pass_idx`.
  - `start` is ignored in WRITE, READ and FLUSH.
- Pattern for pass p:
  - `seed_p` = SEED for p=0 and ~SEED for p=1.
  - Data for address a = `seed_p` + zero-extended a, computed mod 2^32.
- WRITE:
  - Each cycle, port k writes address `base`+(k-1) with `w_enb_k`=1.
  - `base` steps by 8 each cycle. After the cycle where `base` = DEPTH-8, `base` returns to 0 and the FSM goes to READ.
- READ:
  - Each cycle, `r_addr_k` = `base`+(k-1). The same stepping rule applies.
  - The expected data and address for each lane are carried through an RD_LAT-deep pipeline.
  - After the last read issue the FSM goes to FLUSH.
- FLUSH:
  - Lasts RD_LAT cycles and drains the compare pipeline.
  - Then goes to WRITE with `pass_idx`=1 if `pass_idx` was 0; otherwise goes to DONE.
- Compare:
  - A valid lane whose `r_dout_k` differs from its expected word is a mismatch.
  - `err_cnt` increases by the number of mismatching lanes in that cycle (0..8), saturating.
  - The first-error registers load only when `err_cnt` was 0 before the cycle. If several lanes mismatch in that cycle, the lowest-numbered port wins.
- Outputs outside their phase: `w_enb_k`=0, `w_addr_k`=0, `w_din_k`=0, `r_addr_k`=0.
- The RAM must make a write visible to a read issued on the following cycle.

## Timing
- Reset values: all outputs 0 and the FSM in IDLE. `rst` mid-test aborts immediately with no further writes.
- Let `start` be sampled at edge T, with RD_LAT=1:
  - Pass 0: WRITE in cycles T+1..T+256, READ in T+257..T+512, FLUSH in T+513.
  - Pass 1: WRITE in T+514..T+769, READ in T+770..T+1025, FLUSH in T+1026.
  - `done`=1 and `busy`=0 from T+1027.
- General case: `done` rises at T+2·(DEPTH/8·2+RD_LAT)+1.
- `busy` is 1 exactly while in WRITE, READ or FLUSH.

## Structure
- Shared package `lvt_ram_pkg` holds:
  - `BLOCKSIZE`, `ADDR_W`, `DATA_W`=32 and `NPORT`=8.
  - The state enum `bist_state_t`.
  - The pattern function.
- One sub-module `lvt_bist_cmp` contains the 8-lane RD_LAT-deep expected-data and valid pipeline, the comparators, the popcount and the first-error priority encode.

## Test plan
- Fault-free `ram_8R8W`, RD_LAT=1 → `done` at T+1027, `pass`=1, `err_cnt`=0. Write 0x123 in pass 1 carries 0x5A5AFFFF+0x123.
- Flip bit 0 of `r_dout_3` whenever address 0x0A2 is returned → `err_cnt`=2, `first_err_addr`=0x0A2, `first_err_port`=2, `pass`=0.
- Force `r_dout_8`=0 → `err_cnt`=512 and `first_err_port`=7. The first failing address is 0x007, seen at cycle T+258.
- `start` pulsed at T+300 during READ → no effect; `done` still at T+1027.
- `rst` at T+600 → all outputs 0 on the next cycle, no `w_enb` afterwards. A new `start` then completes with `pass`=1.
- `start` while in DONE → `done`/`pass`/`err_cnt` cleared on the next cycle and the test reruns identically.
